// File: rtl/memory_v1.sv
`default_nettype none
// ============================================================================
//  Module   : memory_v1
//  Brief    : 2^K x M register-array memory, synchronous write, combinational
//             read, asynchronous active-low clear of the whole array.
//  Revision : 1.0 - initial release
// ============================================================================
module memory_v1 #(
   parameter int M = 8,
   parameter int K = 4
) (
   output logic [M-1:0] Mout,
   input  logic [M-1:0] Min,
   input  logic         we,
   input  logic         clk,
   input  logic [K-1:0] addr,
   input  logic         rst_n
);

   localparam int c_DEPTH = 1 << K;

   logic [M-1:0] r_mem [c_DEPTH];

   // Reset clears every word and overrides any write attempted while low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we) begin
         r_mem[addr] <= Min;
      end
   end

   assign Mout = r_mem[addr];

endmodule
`default_nettype wire

// File: tb/tb_memory_v1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_v1
//  Brief    : Directed self-checking bench for memory_v1 (default and wide).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_v1;

   logic        clk;
   logic        rst_n;
   logic [7:0]  Min;
   logic [7:0]  Mout;
   logic        we;
   logic [3:0]  addr;
   logic [15:0] Min2;
   logic [15:0] Mout2;
   logic        we2;
   logic [4:0]  addr2;

   int n_checks;
   int n_fail;

   memory_v1 dut (
      .Mout  (Mout),
      .Min   (Min),
      .we    (we),
      .clk   (clk),
      .addr  (addr),
      .rst_n (rst_n)
   );

   memory_v1 #(.M(16), .K(5)) dut_wide (
      .Mout  (Mout2),
      .Min   (Min2),
      .we    (we2),
      .clk   (clk),
      .addr  (addr2),
      .rst_n (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      we    = 1'b0;
      we2   = 1'b0;
      Min   = 8'h00;
      Min2  = 16'h0000;
      addr  = 4'd0;
      addr2 = 5'd0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         addr = 4'(i);
         #1;
         n_checks++;
         if (Mout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_in_reset addr=%0d got=%h exp=00", i, Mout);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         addr = 4'(i);
         #1;
         n_checks++;
         if (Mout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_after addr=%0d got=%h exp=00", i, Mout);
         end
      end
   endtask

   task automatic test_write_hold();
      @(negedge clk);
      we = 1'b1; addr = 4'd7; Min = 8'd127;
      @(posedge clk); #1;
      we = 1'b0;
      n_checks++;
      if (Mout !== 8'd127) begin
         n_fail++;
         $display("FAIL write7 got=%h exp=7f", Mout);
      end
      Min = 8'h33;
      @(posedge clk); #1;
      n_checks++;
      if (Mout !== 8'd127) begin
         n_fail++;
         $display("FAIL hold7_we0 got=%h exp=7f", Mout);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      we = 1'b1; addr = 4'd8; Min = 8'd255;
      @(posedge clk);
      @(posedge clk); #1;
      we = 1'b0;
      addr = 4'd7; #1;
      n_checks++;
      if (Mout !== 8'd127) begin
         n_fail++;
         $display("FAIL comb_read7 got=%h exp=7f", Mout);
      end
      addr = 4'd8; #1;
      n_checks++;
      if (Mout !== 8'd255) begin
         n_fail++;
         $display("FAIL comb_read8 got=%h exp=ff", Mout);
      end
      addr = 4'd0; #1;
      n_checks++;
      if (Mout !== 8'd0) begin
         n_fail++;
         $display("FAIL comb_read0 got=%h exp=00", Mout);
      end
      // Last write wins when we stays high across edges
      @(negedge clk);
      we = 1'b1; addr = 4'd9; Min = 8'h11;
      @(negedge clk);
      Min = 8'h22;
      @(posedge clk); #1;
      we = 1'b0;
      n_checks++;
      if (Mout !== 8'h22) begin
         n_fail++;
         $display("FAIL last_write_wins got=%h exp=22", Mout);
      end
   endtask

   task automatic test_min_change();
      @(negedge clk);
      addr = 4'd3; we = 1'b0; #1;
      n_checks++;
      if (Mout !== 8'h00) begin
         n_fail++;
         $display("FAIL pre_write3 got=%h exp=00", Mout);
      end
      we = 1'b1; Min = 8'hA5;
      #2 Min = 8'h5A;
      #1;
      n_checks++;
      if (Mout !== 8'h00) begin
         n_fail++;
         $display("FAIL before_edge3 got=%h exp=00", Mout);
      end
      @(posedge clk); #1;
      we = 1'b0;
      n_checks++;
      if (Mout !== 8'h5A) begin
         n_fail++;
         $display("FAIL after_edge3 got=%h exp=5a", Mout);
      end
      // Address moves between edges: only the value at the edge counts
      @(negedge clk);
      we = 1'b1; addr = 4'd5; Min = 8'h77;
      #2 addr = 4'd6;
      @(posedge clk); #1;
      we = 1'b0;
      n_checks++;
      if (Mout !== 8'h77) begin
         n_fail++;
         $display("FAIL addr_at_edge6 got=%h exp=77", Mout);
      end
      addr = 4'd5; #1;
      n_checks++;
      if (Mout !== 8'h00) begin
         n_fail++;
         $display("FAIL addr_not_edge5 got=%h exp=00", Mout);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      we = 1'b0; addr = 4'd7;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (Mout !== 8'h00) begin
         n_fail++;
         $display("FAIL async_clear7 got=%h exp=00", Mout);
      end
      addr = 4'd8; #1;
      n_checks++;
      if (Mout !== 8'h00) begin
         n_fail++;
         $display("FAIL async_clear8 got=%h exp=00", Mout);
      end
      we = 1'b1; Min = 8'hEE;
      @(posedge clk); #1;
      n_checks++;
      if (Mout !== 8'h00) begin
         n_fail++;
         $display("FAIL write_in_reset got=%h exp=00", Mout);
      end
      @(negedge clk);
      we = 1'b0;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (Mout !== 8'h00) begin
         n_fail++;
         $display("FAIL after_reset8 got=%h exp=00", Mout);
      end
      @(negedge clk);
      we = 1'b1; Min = 8'h42;
      @(posedge clk); #1;
      we = 1'b0;
      n_checks++;
      if (Mout !== 8'h42) begin
         n_fail++;
         $display("FAIL resume_write8 got=%h exp=42", Mout);
      end
   endtask

   task automatic test_wide();
      @(negedge clk);
      we2 = 1'b1; addr2 = 5'd31; Min2 = 16'hFFFF;
      @(posedge clk); #1;
      we2 = 1'b0;
      n_checks++;
      if (Mout2 !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wide_read31 got=%h exp=ffff", Mout2);
      end
      addr2 = 5'd30; #1;
      n_checks++;
      if (Mout2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL wide_read30 got=%h exp=0000", Mout2);
      end
      addr2 = 5'd15; #1;
      n_checks++;
      if (Mout2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL wide_read15 got=%h exp=0000", Mout2);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_write_hold();
      test_back_to_back();
      test_min_change();
      test_async_reset();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_v1.md
MEMORY_V1 -- requirements
Module: memory_v1

Interface
REQ-001 SHALL have parameter M, default 8, data word width in bits.
REQ-002 SHALL have parameter K, default 4, address width in bits; depth = 2^K words (16 by default).
REQ-003 SHALL have port clk  input  1  single clock; all writes occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Mout  output  M  read data, the word at addr.
REQ-006 SHALL have port Min  input  M  write data.
REQ-007 SHALL have port we  input  1  write enable, active-high.
REQ-008 SHALL have port addr  input  K  shared read/write word address.
REQ-009 SHALL use positional port order Mout, Min, we, clk, addr, rst_n, with parameter order M, K.

Function
REQ-010 SHALL hold 2^K words of M bits each in an internal register array.
REQ-011 SHALL write Min into word[addr] on the rising clk edge when we=1 and rst_n=1.
REQ-012 SHALL leave all words unchanged on any rising edge with we=0.
REQ-013 SHALL drive Mout combinationally as word[addr], with zero-cycle latency; an addr change updates Mout in the same timestep, with no clock needed.
REQ-014 SHALL make Mout show the newly written value right after the write edge when reading and writing the same address.
REQ-015 SHALL ignore Min and addr changes between edges for writing; only values present at the rising edge are stored.
REQ-016 SHALL hold we high across multiple rising edges as repeated writes of the current Min to the current addr, and the last write wins.
REQ-017 SHALL treat all 2^K addresses as valid (0 to 2^K-1); out-of-range addresses are impossible by width.
REQ-018 SHALL have no read enable, no output register, and no handshake; we is the only control.
REQ-019 SHALL size all widths from M and K only; no hard-coded 8 or 4.

Reset
REQ-020 SHALL clear every word to 0 asynchronously while rst_n=0, independent of clk.
REQ-021 SHALL drive Mout to 0 during reset for any addr, as a consequence of the cleared array.
REQ-022 SHALL ignore writes while rst_n=0; reset has priority over we.
REQ-023 SHALL resume normal writes on the first rising clk edge after rst_n returns to 1.
REQ-024 SHALL clear the whole array, including a word written in the same cycle, when rst_n is asserted mid-operation.

Verification
REQ-025 SHALL pass this scenario: Reset then reading all 16 addresses -> Mout=0 for every addr.
REQ-026 SHALL pass this scenario: we=1, addr=7, Min=127 across one rising edge, then we=0 -> Mout=127 with addr=7; a later Min change with we=0 leaves word 7 at 127.
REQ-027 SHALL pass this scenario: we=1, addr=8, Min=255 held over two rising edges, then we=0, addr=7 -> Mout=127; addr=8 -> Mout=255; addr=0 -> Mout=0, each with no clock edge between addr changes.
REQ-028 SHALL pass this scenario: we=1, addr=3, Min=0xA5 with Min changed to 0x5A before the edge -> word 3 = 0x5A; Mout changes from 0 to 0x5A right after the edge.
REQ-029 SHALL pass this scenario: after writing words 7 and 8, assert rst_n=0 between clk edges -> Mout=0 immediately for addr 7 and 8; a write attempted during reset is not stored.
REQ-030 SHALL pass this scenario: instance with M=16, K=5 writing 0xFFFF to addr 31 -> readback 0xFFFF at addr 31 and 0 at addr 30.
